// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide, with a fixed 35-cycle busy window for every operation.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] b_q;
    logic [63:0] prod_q;
    logic        neg_q;
    logic [5:0]  cnt_q;
    logic        done_q;
    logic [31:0] result_q;

    logic        sa;
    logic        sb;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        is_div;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] calc_next;
    logic [63:0] mul_res;
    logic        ovf;
    logic [31:0] fix_result;

    assign sa = rs1_q[31] && (op_q == OP_MULH || op_q == OP_MULHSU || op_q == OP_DIV || op_q == OP_REM);
    assign sb = rs2_q[31] && (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM);
    assign abs_a = sa ? (32'd0 - rs1_q) : rs1_q;
    assign abs_b = sb ? (32'd0 - rs2_q) : rs2_q;
    assign is_div = op_q[2];

    // prod_q doubles as {remainder, quotient} during division; low half starts as |dividend|.
    assign mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, b_q} : 33'd0);
    assign div_sh  = prod_q[63:31];
    assign div_ge  = (div_sh >= {1'b0, b_q});
    assign div_rem = div_sh[31:0] - b_q;
    assign calc_next = !is_div ? {mul_sum, prod_q[31:1]}
                     : div_ge  ? {div_rem, prod_q[30:0], 1'b1}
                     :           {prod_q[62:0], 1'b0};

    assign mul_res = neg_q ? (64'd0 - prod_q) : prod_q;
    assign ovf     = (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fix_result = 32'd0;
        case (op_q)
            OP_MUL:                       fix_result = mul_res[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = mul_res[63:32];
            OP_DIV, OP_DIVU: begin
                if (rs2_q == 32'd0)              fix_result = 32'hFFFF_FFFF;
                else if (ovf && op_q == OP_DIV)  fix_result = 32'h8000_0000;
                else                             fix_result = neg_q ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
            end
            OP_REM, OP_REMU: begin
                if (rs2_q == 32'd0)              fix_result = rs1_q;
                else if (ovf && op_q == OP_REM)  fix_result = 32'd0;
                else                             fix_result = neg_q ? (32'd0 - prod_q[63:32]) : prod_q[63:32];
            end
            default:                      fix_result = 32'd0;
        endcase
    end

    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            b_q      <= 32'd0;
            prod_q   <= 64'd0;
            neg_q    <= 1'b0;
            cnt_q    <= 6'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        op_q    <= op_i;
                        rs1_q   <= rs1_i;
                        rs2_q   <= rs2_i;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    b_q     <= abs_b;
                    prod_q  <= {32'd0, abs_a};
                    // Remainder sign follows the dividend alone.
                    neg_q   <= (op_q == OP_REM) ? sa : (sa ^ sb);
                    cnt_q   <= 6'd0;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    prod_q <= calc_next;
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, fixed latency, special
// cases, kill and mid-operation reset.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        kill_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    // Cycle k is the k-th cycle after the accepting edge; done must land in cycle 35,
    // the last of exactly 35 busy cycles, and ready must be back in cycle 36.
    task automatic watch(input string tag, input logic [31:0] exp);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        logic [31:0] res = 32'd0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_at = k;
                res = result_o;
            end
            if (!busy_o) break;
        end
        check({tag, "_result"}, res, exp);
        check({tag, "_done_cycle"}, done_at, 35);
        check({tag, "_busy_cycles"}, busy_cnt, 35);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
        check({tag, "_result_held"}, result_o, exp);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        watch(tag, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_done",  {31'd0, done_o},  32'd0);
        check("rst_result", result_o, 32'd0);
        rst_i = 1'b0;

        run("mul_neg1x2",   OP_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE);
        run("mulh_m1m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run("mulhsu_m1m1",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulhu_m1m1",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mul_7xm3",     OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mulh_min_min", OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulh_m2x3",    OP_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
        run("div_m7_2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run("rem_m7_2",     OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run("div_7_m2",     OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run("rem_7_m2",     OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001);
        run("divu_max_1",   OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);
        run("div_by0",      OP_DIV,    32'h1234_5678, 32'd0,         32'hFFFF_FFFF);
        run("rem_by0",      OP_REM,    32'h1234_5678, 32'd0,         32'h1234_5678);
        run("div_neg_by0",  OP_DIV,    32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF);
        run("rem_neg_by0",  OP_REM,    32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8);
        run("divu_by0",     OP_DIVU,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF);
        run("remu_by0",     OP_REMU,   32'h1234_5678, 32'd0,         32'h1234_5678);
        run("div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run("divu_7_2",     OP_DIVU,   32'd7,         32'd2,         32'd3);
        run("remu_7_2",     OP_REMU,   32'd7,         32'd2,         32'd1);

        // kill together with valid in IDLE: nothing accepted.
        @(negedge clk_i);
        valid_i = 1'b1; kill_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd3; rs2_i = 32'd3;
        @(posedge clk_i);
        #1 valid_i = 1'b0; kill_i = 1'b0;
        check("killvalid_busy",  {31'd0, busy_o},  32'd0);
        check("killvalid_ready", {31'd0, ready_o}, 32'd1);

        // kill during CALC iteration 10 (cycle 12 after accept).
        issue(OP_MUL, 32'd5, 32'd6);
        repeat (12) @(negedge clk_i);
        check("kill_busy_before", {31'd0, busy_o}, 32'd1);
        check("kill_done_before", {31'd0, done_o}, 32'd0);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        check("kill_busy",   {31'd0, busy_o},  32'd0);
        check("kill_ready",  {31'd0, ready_o}, 32'd1);
        check("kill_done",   {31'd0, done_o},  32'd0);
        check("kill_result", result_o, 32'd1);
        run("divu_after_kill", OP_DIVU, 32'd100, 32'd7, 32'd14);

        // reset mid-CALC with valid held high throughout.
        issue(OP_MUL, 32'd3, 32'd5);
        repeat (20) @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
        @(posedge clk_i);
        #1;
        check("midrst_ready",  {31'd0, ready_o}, 32'd1);
        check("midrst_busy",   {31'd0, busy_o},  32'd0);
        check("midrst_done",   {31'd0, done_o},  32'd0);
        check("midrst_result", result_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 check("midrst_no_accept", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        watch("divu_after_rst", 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
